water_inlet_arbiter: RTL and testbench

WATER_INLET_ARBITER -- requirements
Module: water_inlet_arbiter

---
 rtl/water_inlet_arbiter.sv | 138 +++++++++++++
 tb/tb_water_inlet_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/water_inlet_arbiter.sv
// Round-robin arbiter granting a shared water inlet valve to one washer at a time,
// with pausable fill timing, abort on request withdrawal and a forced settle gap.
module water_inlet_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [CNT_W-1:0] fill_len,
    input  logic             pause,
    output logic [N_REQ-1:0] grant,
    output logic             valve_open,
    output logic [N_REQ-1:0] fill_done,
    output logic             fill_abort,
    output logic [CNT_W-1:0] fill_cnt,
    output logic             busy
);

    localparam int unsigned      IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        GAP
    } state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] owner, owner_d;
    logic [IDX_W-1:0] last_owner, last_owner_d;
    logic [IDX_W-1:0] win_idx, rr_pos;
    logic             win_vld;
    int unsigned      rr_idx;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] fill_cnt_d;
    logic [3:0]       gap_cnt, gap_cnt_d;
    logic [N_REQ-1:0] grant_d, fill_done_d;
    logic             fill_abort_d;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        rr_idx  = 0;
        rr_pos  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            rr_idx = (32'(last_owner) + 32'd1 + k) % N_REQ;
            rr_pos = IDX_W'(rr_idx);
            if (!win_vld && req[rr_pos]) begin
                win_vld = 1'b1;
                win_idx = rr_pos;
            end
        end
    end

    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_owner_d = last_owner;
        len_d        = len_q;
        fill_cnt_d   = fill_cnt;
        gap_cnt_d    = gap_cnt;
        grant_d      = grant;
        fill_done_d  = '0;
        fill_abort_d = 1'b0;
        case (state)
            IDLE: begin
                if (!pause && win_vld) begin
                    state_d    = FILL;
                    owner_d    = win_idx;
                    grant_d    = N_REQ'(1) << win_idx;
                    len_d      = (fill_len == '0) ? CNT_W'(1) : fill_len;
                    fill_cnt_d = '0;
                end
            end
            FILL: begin
                // Withdrawal wins over a coincident completion and ignores pause.
                if (!req[owner]) begin
                    fill_abort_d = 1'b1;
                    state_d      = GAP;
                    grant_d      = '0;
                    last_owner_d = owner;
                    gap_cnt_d    = GAP_LOAD;
                end else if (!pause) begin
                    fill_cnt_d = fill_cnt + CNT_W'(1);
                    if (fill_cnt == len_q - CNT_W'(1)) begin
                        fill_done_d  = N_REQ'(1) << owner;
                        state_d      = GAP;
                        grant_d      = '0;
                        last_owner_d = owner;
                        gap_cnt_d    = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_IDX;
            len_q      <= CNT_W'(1);
            fill_cnt   <= '0;
            gap_cnt    <= '0;
            grant      <= '0;
            fill_done  <= '0;
            fill_abort <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_owner <= last_owner_d;
            len_q      <= len_d;
            fill_cnt   <= fill_cnt_d;
            gap_cnt    <= gap_cnt_d;
            grant      <= grant_d;
            fill_done  <= fill_done_d;
            fill_abort <= fill_abort_d;
            busy       <= (state_d != IDLE);
        end
    end

    // Pause closes the valve within the same cycle, not one edge later.
    assign valve_open = (state == FILL) && !pause;

endmodule

// File: tb/tb_water_inlet_arbiter.sv
// Directed bench for water_inlet_arbiter: single fill, reset mid-fill, round-robin,
// pause, withdrawal, zero-length fill and withdrawal on the final open cycle.
module tb_water_inlet_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] fill_len;
    logic        pause;
    logic [3:0]  grant;
    logic        valve_open;
    logic [3:0]  fill_done;
    logic        fill_abort;
    logic [15:0] fill_cnt;
    logic        busy;

    int tests = 0;
    int fails = 0;
    logic [3:0] rr_exp [0:4];

    always #5 clk = ~clk;

    water_inlet_arbiter #(
        .N_REQ(4),
        .CNT_W(16),
        .GAP_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .fill_len(fill_len),
        .pause(pause),
        .grant(grant),
        .valve_open(valve_open),
        .fill_done(fill_done),
        .fill_abort(fill_abort),
        .fill_cnt(fill_cnt),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Land just after the rising edge; inputs set here apply to the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        fill_len = 16'd0;
        pause    = 1'b0;
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;

        #3;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valve", 32'(valve_open), 32'h0);
        check("rst_done", 32'(fill_done), 32'h0);
        check("rst_abort", 32'(fill_abort), 32'h0);
        check("rst_cnt", 32'(fill_cnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        #4 rst_n = 1'b1;

        // Single fill of 5 cycles; fill_len change after grant is ignored.
        step();
        req = 4'b0001; fill_len = 16'd5;
        step();
        fill_len = 16'd9;
        check("s_grant", 32'(grant), 32'h1);
        check("s_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 5; i++) begin
            check("s_valve", 32'(valve_open), 32'h1);
            check("s_cnt", 32'(fill_cnt), 32'(i));
            check("s_done_low", 32'(fill_done), 32'h0);
            step();
        end
        req = 4'b0000;
        check("s_done", 32'(fill_done), 32'h1);
        check("s_grant_off", 32'(grant), 32'h0);
        check("s_valve_off", 32'(valve_open), 32'h0);
        check("s_cnt_final", 32'(fill_cnt), 32'h5);
        step();
        check("s_done_pulse", 32'(fill_done), 32'h0);
        check("s_gap_busy", 32'(busy), 32'h1);
        step();
        check("s_idle_busy", 32'(busy), 32'h0);
        check("s_idle_cnt", 32'(fill_cnt), 32'h5);

        // Reset during a fill, then round-robin restarts at req[0].
        req = 4'b0010; fill_len = 16'd10;
        step();
        check("r_grant", 32'(grant), 32'h2);
        step();
        check("r_cnt", 32'(fill_cnt), 32'h1);
        rst_n = 1'b0;
        #1;
        check("r_valve", 32'(valve_open), 32'h0);
        check("r_grant0", 32'(grant), 32'h0);
        check("r_busy", 32'(busy), 32'h0);
        check("r_cnt0", 32'(fill_cnt), 32'h0);
        check("r_done", 32'(fill_done), 32'h0);
        check("r_abort", 32'(fill_abort), 32'h0);
        req = 4'b1111; fill_len = 16'd2;
        #1 rst_n = 1'b1;

        step();
        for (int f = 0; f < 5; f++) begin
            check("rr_grant", 32'(grant), 32'(rr_exp[f]));
            check("rr_valve0", 32'(valve_open), 32'h1);
            check("rr_cnt0", 32'(fill_cnt), 32'h0);
            step();
            check("rr_valve1", 32'(valve_open), 32'h1);
            step();
            if (f == 4) req = 4'b0000;
            check("rr_done", 32'(fill_done), 32'(rr_exp[f]));
            check("rr_gap_valve0", 32'(valve_open), 32'h0);
            step();
            check("rr_gap_valve1", 32'(valve_open), 32'h0);
            check("rr_gap_busy", 32'(busy), 32'h1);
            step();
            check("rr_idle_valve", 32'(valve_open), 32'h0);
            check("rr_idle_busy", 32'(busy), 32'h0);
            step();
        end
        check("rr_end_grant", 32'(grant), 32'h0);
        check("rr_end_busy", 32'(busy), 32'h0);

        // Pause for 3 cycles after the second open cycle.
        req = 4'b0001; fill_len = 16'd4;
        step();
        check("p_grant", 32'(grant), 32'h1);
        check("p_valve_c1", 32'(valve_open), 32'h1);
        step();
        check("p_valve_c2", 32'(valve_open), 32'h1);
        check("p_cnt_c2", 32'(fill_cnt), 32'h1);
        step();
        pause = 1'b1;
        #1;
        check("p_valve_paused", 32'(valve_open), 32'h0);
        check("p_cnt_hold", 32'(fill_cnt), 32'h2);
        step();
        check("p_valve_paused2", 32'(valve_open), 32'h0);
        step();
        check("p_cnt_hold3", 32'(fill_cnt), 32'h2);
        check("p_grant_hold", 32'(grant), 32'h1);
        step();
        pause = 1'b0;
        #1;
        check("p_valve_resume", 32'(valve_open), 32'h1);
        check("p_cnt_resume", 32'(fill_cnt), 32'h2);
        step();
        check("p_valve_last", 32'(valve_open), 32'h1);
        check("p_no_early_done", 32'(fill_done), 32'h0);
        step();
        req = 4'b0000;
        check("p_done", 32'(fill_done), 32'h1);
        check("p_cnt_final", 32'(fill_cnt), 32'h4);

        // Pause in IDLE blocks arbitration; then withdrawal of owner 2 mid-fill.
        step();
        step();
        pause = 1'b1; req = 4'b0100; fill_len = 16'd10;
        step();
        check("w_idle_pause_grant", 32'(grant), 32'h0);
        check("w_idle_pause_valve", 32'(valve_open), 32'h0);
        check("w_idle_pause_busy", 32'(busy), 32'h0);
        pause = 1'b0;
        step();
        check("w_grant", 32'(grant), 32'h4);
        req = 4'b1100;
        step();
        step();
        step();
        check("w_cnt3", 32'(fill_cnt), 32'h3);
        check("w_grant_kept", 32'(grant), 32'h4);
        req = 4'b1000;
        step();
        check("w_abort", 32'(fill_abort), 32'h1);
        check("w_no_done", 32'(fill_done), 32'h0);
        check("w_grant0", 32'(grant), 32'h0);
        check("w_valve0", 32'(valve_open), 32'h0);
        check("w_cnt_keep", 32'(fill_cnt), 32'h3);
        step();
        check("w_abort_pulse", 32'(fill_abort), 32'h0);
        check("w_gap_cnt", 32'(fill_cnt), 32'h3);
        step();
        check("w_idle_busy", 32'(busy), 32'h0);
        check("w_idle_cnt", 32'(fill_cnt), 32'h3);
        fill_len = 16'd0;
        step();
        check("z_grant3", 32'(grant), 32'h8);
        check("z_valve", 32'(valve_open), 32'h1);
        check("z_cnt0", 32'(fill_cnt), 32'h0);
        step();
        req = 4'b0000;
        check("z_done", 32'(fill_done), 32'h8);
        check("z_valve_off", 32'(valve_open), 32'h0);
        check("z_cnt1", 32'(fill_cnt), 32'h1);

        // Withdrawal on the final open cycle: abort only.
        step();
        step();
        req = 4'b0001; fill_len = 16'd2;
        step();
        check("c_grant", 32'(grant), 32'h1);
        step();
        check("c_cnt1", 32'(fill_cnt), 32'h1);
        req = 4'b0000;
        step();
        check("c_abort", 32'(fill_abort), 32'h1);
        check("c_no_done", 32'(fill_done), 32'h0);
        check("c_cnt_keep", 32'(fill_cnt), 32'h1);
        check("c_grant0", 32'(grant), 32'h0);

        // GAP length is unaffected by pause.
        pause = 1'b1;
        step();
        check("g_busy", 32'(busy), 32'h1);
        check("g_valve", 32'(valve_open), 32'h0);
        step();
        check("g_idle", 32'(busy), 32'h0);
        pause = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
